// File: rtl/cpu6_fetch_pkg.sv
// cpu6 fetch unit shared definitions.
// Datapath width, NOP encoding and reset vector used by the fetch stage.
package cpu6_fetch_pkg;

   localparam int CPU6_XLEN = 32;

   localparam logic [31:0] CPU6_NOP = 32'h0000_0013;

   localparam logic [CPU6_XLEN-1:0] CPU6_RESET_PC = '0;

endpackage

// File: rtl/cpu6_fetch_fifo.sv
// cpu6 fetch buffer: synchronous FIFO with push/pop/flush and head peek.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop, flush, head, count, full, empty.
module cpu6_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   // flush discards both the head and anything arriving this cycle
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cpu6_fetch_stage.sv
// cpu6 instruction fetch stage: owns fetch PC, credit-limited imem requests,
// response buffering, stall and redirect. Ports: clk, reset (sync, active-low),
// imem_req_*/imem_resp_*, redirect_valid/redirect_pc, stall, pc/instr/instr_valid.
module cpu6_fetch_stage
   import cpu6_fetch_pkg::*;
#(
   parameter int              XLEN     = CPU6_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU6_RESET_PC),
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr,
   output logic            instr_valid
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = CW + 1;

   logic [XLEN-1:0]    fetch_pc;
   logic [XLEN-1:0]    resp_pc;
   logic [XLEN-1:0]    target;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      drop_cnt;
   logic [CW-1:0]      count;
   logic [WW-1:0]      credit;
   logic [XLEN+31:0]   head;
   logic               full;
   logic               empty;
   logic               pop;
   logic               push;
   logic               req_fire;
   logic               resp_fire;
   logic               dropping;

   assign target    = redirect_pc & ~XLEN'(3);
   assign pop       = !stall && !empty;
   // slots in use after this cycle's pop; a new request needs a free slot
   assign credit    = WW'(outstanding) + WW'(count) - WW'(pop);
   assign imem_req_valid = reset && !redirect_valid && (credit < WW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_fire = imem_resp_valid;
   assign dropping  = (drop_cnt != '0);
   assign push      = resp_fire && !dropping && !redirect_valid;

   cpu6_fetch_fifo #(
      .WIDTH (XLEN + 32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .wdata ({resp_pc, imem_resp_instr}),
      .pop   (pop),
      .flush (redirect_valid),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
         if (redirect_valid) begin
            fetch_pc <= target;
            resp_pc  <= target;
            // everything still in flight belongs to the old path
            drop_cnt <= outstanding - CW'(resp_fire);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)     resp_pc  <= resp_pc + XLEN'(4);
            if (resp_fire && dropping) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   assign instr_valid = !empty;
   assign pc          = empty ? '0 : head[XLEN+31:32];
   assign instr       = empty ? CPU6_NOP : head[31:0];

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset) !(push && full && !pop)
   );

endmodule
